data_mem_pipe: RTL
==================

# data_mem_pipe

Parametrised, pipelined successor to the single-cycle data memory. It serves the CPU's load/store unit through a valid/ready request port and returns a registered response after a configurable latency. Responses flag misaligned or out-of-range accesses. After every reset the block clears its own contents before accepting requests. It sits between the load/store unit and the writeback stage and keeps the existing 4-bit `mem_en` access encoding.

## Interface
Parameters:
- `DEPTH_WORDS`, default 1024: number of 32-bit words. Power of two, ≥4.
- `READ_LAT`, default 1: cycles from request accept to response. Legal values 1–3.
- `BASE_ADDR`, default 32'h0000_0000: byte address of word 0. Must be aligned to DEPTH_WORDS*4.

Ports:
- `clk` in 1: single clock. All logic is rising-edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: block can accept a request. Transfer occurs on an edge where `req_valid & req_ready`.
- `mem_en` in 4: access encoding.
  - `[3]`: sign-extend on load.
  - `[2]`: 1 = store, 0 = load.
  - `[1:0]`: size. 01 = byte, 10 = half, 11 = word, 00 = no-op.
- `addr` in 32: byte address.
- `data_in` in 32: store data. Stores use the low bits only.
- `rsp_valid` out 1: one-cycle pulse marking a response.
- `data_out` out 32: load result.
- `rsp_fault` out 1: access was misaligned or out of range.

## Operation
- FSM states:
  - INIT: reset entry. Writes zero to word `clr_idx`, then increments `clr_idx`. Goes to RUN after index DEPTH_WORDS-1 is written. `req_ready`=0 throughout.
  - RUN: `req_ready`=1.
- Address decode: `off = addr - BASE_ADDR`. Word index is `off[clog2(DEPTH_WORDS)+1:2]`.
- Out of range: any set bit in `off` above that field.
- Misaligned: half with `off[0]`=1, or word with `off[1:0]`≠0. Byte accesses are never misaligned.
- Fault: out of range or misaligned. A faulting access performs no write, returns `data_out`=0 and `rsp_fault`=1.
- Store: merges byte lanes into the target word at the accept edge.
  - Byte: `data_in[7:0]` goes to lane `off[1:0]`.
  - Half: `data_in[15:0]` goes to lanes `off[1]*2 +: 2`.
  - Word: the whole word is written.
  - Response: `data_out`=0, `rsp_fault`=0.
- Load: reads the word at the accept edge, then extracts the lane.
  - `mem_en[3]`=1: sign-extend to 32 bits. `mem_en[3]`=0: zero-extend.
  - Word loads ignore `mem_en[3]`.
- No-op (`mem_en[1:0]`=00): accepted but produces no response, no write and no fault.
- Ordering: a load accepted the cycle after a store to the same word returns the new data. There are no hazards, because the store commits at its own accept edge.
- Only one request is accepted per cycle.
- There is no response backpressure. The consumer must always sink `rsp_valid`.

## Timing
- Reset: while `rst`=1, all outputs are 0 and the FSM goes to INIT with `clr_idx`=0.
- After `rst` falls, INIT lasts exactly DEPTH_WORDS cycles. `req_ready` rises on the edge after the last clear write.
- Latency: a request accepted at edge N raises `rsp_valid` for one cycle, starting right after edge N+READ_LAT-1. READ_LAT=1 gives a response in the cycle immediately after accept.
- The response pipeline is a READ_LAT-deep valid/data/fault shift.
- Back-to-back accepts give back-to-back responses at full throughput.
- `data_out` and `rsp_fault` hold their last response values between pulses.
- Reset mid-INIT: `clr_idx` restarts at 0.
- Reset mid-pipeline: in-flight responses are dropped and `rsp_valid`=0 from the next cycle. Stores already committed are cleared again by INIT.
- `clr_idx` wraps never. It is compared against DEPTH_WORDS-1 before incrementing.

## Structure
- Package `data_mem_pkg` holds:
  - Constants `MEM_EN_SIGNED`=3 and `MEM_EN_STORE`=2.
  - Size codes `SZ_NONE`/`SZ_B`/`SZ_H`/`SZ_W` = 2'b00/01/10/11.
  - The FSM state enum {INIT, RUN}.
- Sub-module `data_mem_align` is combinational. It does store lane merge, load extract/extend, and the misalign check, and is shared with future cache work.
- Storage is an inferred single-port RAM with byte write enables.

## Test plan
- Reset with DEPTH_WORDS=16, then deassert `rst` -> `req_ready`=0 for 16 cycles, 1 on cycle 17. A load word at 0x0 returns 0x0000_0000.
- Store word 0xDEADBEEF at 0x8, then load byte signed at 0xB and load half unsigned at 0xA -> 0xFFFF_FFDE and 0x0000_DEAD, one cycle after each accept (READ_LAT=1).
- Store byte 0x80 at 0x5, then load byte signed and unsigned at 0x5 -> 0xFFFF_FF80 and 0x0000_0080. A load word at 0x4 shows only lane 1 changed.
- Load word at 0x6, load half at 0x3, store word at 0x40 (DEPTH_WORDS=16) -> each returns `rsp_fault`=1 and `data_out`=0. A later load at 0x0 shows no write occurred.
- READ_LAT=3: four back-to-back loads -> four consecutive `rsp_valid` pulses starting 3 cycles after the first accept, in request order.
- Assert `rst` with two loads in flight and mid-INIT -> no `rsp_valid` afterwards. INIT runs a full DEPTH_WORDS cycles and previously stored data reads as 0.

Source files
------------

// File: rtl/data_mem_pkg.sv
// data_mem_pkg
//   Shared definitions for the pipelined data memory and its lane-alignment
//   helper: mem_en bit positions, access size codes, the controller state
//   type and the byte-lane write mask function.
package data_mem_pkg;

    localparam int unsigned MEM_EN_SIGNED = 3;
    localparam int unsigned MEM_EN_STORE  = 2;

    typedef enum logic [1:0] {
        SZ_NONE = 2'b00,
        SZ_B    = 2'b01,
        SZ_H    = 2'b10,
        SZ_W    = 2'b11
    } size_e;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Byte lanes touched by an access of the given size at the given
    // low-order byte offset.
    function automatic logic [3:0] lane_mask(input logic [1:0] size,
                                             input logic [1:0] lane);
        case (size)
            SZ_B:    lane_mask = 4'b0001 << lane;
            SZ_H:    lane_mask = lane[1] ? 4'b1100 : 4'b0011;
            SZ_W:    lane_mask = 4'b1111;
            default: lane_mask = 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_align.sv
// data_mem_align
//   Combinational byte-lane logic for 32-bit data accesses.
//   Ports:
//     size_i      access size code (SZ_*)
//     sign_i      sign-extend sub-word loads
//     lane_i      low two bits of the byte offset
//     st_data_i   store data (low bits significant)
//     ld_word_i   full word read from storage
//     st_wdata_o  store data replicated into every lane it may occupy
//     st_be_o     byte write enables for the store
//     ld_data_o   extracted and extended load result
//     misalign_o  half on an odd byte, or word not on a word boundary
module data_mem_align
    import data_mem_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic        sign_i,
    input  logic [1:0]  lane_i,
    input  logic [31:0] st_data_i,
    input  logic [31:0] ld_word_i,
    output logic [31:0] st_wdata_o,
    output logic [3:0]  st_be_o,
    output logic [31:0] ld_data_o,
    output logic        misalign_o
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        st_wdata_o = '0;
        st_be_o    = lane_mask(size_i, lane_i);
        ld_data_o  = '0;
        misalign_o = 1'b0;
        ld_byte    = ld_word_i[{lane_i, 3'b000} +: 8];
        ld_half    = lane_i[1] ? ld_word_i[31:16] : ld_word_i[15:0];
        case (size_i)
            SZ_B: begin
                // Replicate so that the byte enables alone pick the lane.
                st_wdata_o = {4{st_data_i[7:0]}};
                ld_data_o  = {{24{sign_i & ld_byte[7]}}, ld_byte};
            end
            SZ_H: begin
                st_wdata_o = {2{st_data_i[15:0]}};
                ld_data_o  = {{16{sign_i & ld_half[15]}}, ld_half};
                misalign_o = lane_i[0];
            end
            SZ_W: begin
                st_wdata_o = st_data_i;
                ld_data_o  = ld_word_i;
                misalign_o = |lane_i;
            end
            default: begin
                st_be_o = '0;
            end
        endcase
    end

endmodule

// File: rtl/data_mem_pipe.sv
// data_mem_pipe
//   Pipelined 32-bit data memory for the load/store unit. Clears its own
//   contents after every reset, then accepts one valid/ready request per
//   cycle and returns a response READ_LAT cycles after accept.
//   Ports:
//     clk, rst    rising-edge clock, synchronous active-high reset
//     req_valid   request present
//     req_ready   high once the post-reset clear has finished
//     mem_en      [3] sign-extend, [2] store, [1:0] size (00 = no-op)
//     addr        byte address
//     data_in     store data
//     rsp_valid   one-cycle response pulse
//     data_out    load result (held between pulses)
//     rsp_fault   misaligned or out-of-range access (held between pulses)
module data_mem_pipe
    import data_mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned READ_LAT    = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  mem_en,
    input  logic [31:0] addr,
    input  logic [31:0] data_in,
    output logic        rsp_valid,
    output logic [31:0] data_out,
    output logic        rsp_fault
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    // ---------------- clear-then-run controller ----------------
    state_e        state_q, state_d;
    logic [AW-1:0] clr_idx_q, clr_idx_d;
    logic          clr_we;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= INIT;
            clr_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        clr_we    = 1'b0;
        case (state_q)
            INIT: begin
                clr_we = 1'b1;
                if (clr_idx_q == AW'(DEPTH_WORDS - 1)) begin
                    state_d = RUN;
                end else begin
                    clr_idx_d = clr_idx_q + AW'(1);
                end
            end
            RUN: begin
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    assign req_ready = ~rst & (state_q == RUN);

    // ---------------- request decode ----------------
    logic [31:0]   off;
    logic [AW-1:0] word_idx;
    logic          oor;
    logic [1:0]    req_size;
    logic          req_store, req_sign;
    logic          accept, active, fault, do_store, do_load;

    logic [31:0]   req_st_wdata, req_ld_data;
    logic [3:0]    req_st_be;
    logic          req_misalign;

    assign off       = addr - BASE_ADDR;
    assign word_idx  = off[AW+1:2];
    assign oor       = |(off >> (AW + 2));
    assign req_size  = mem_en[1:0];
    assign req_store = mem_en[MEM_EN_STORE];
    assign req_sign  = mem_en[MEM_EN_SIGNED];

    assign accept   = req_valid & req_ready;
    assign active   = accept & (req_size != SZ_NONE);
    assign fault    = oor | req_misalign;
    assign do_store = active & req_store & ~fault;
    assign do_load  = active & ~req_store & ~fault;

    data_mem_align u_req_align (
        .size_i     (req_size),
        .sign_i     (req_sign),
        .lane_i     (off[1:0]),
        .st_data_i  (data_in),
        .ld_word_i  ('0),
        .st_wdata_o (req_st_wdata),
        .st_be_o    (req_st_be),
        .ld_data_o  (req_ld_data),
        .misalign_o (req_misalign)
    );

    // ---------------- storage ----------------
    logic [31:0]   mem_q [DEPTH_WORDS];
    logic [31:0]   rdata_q;
    logic [AW-1:0] ram_idx;
    logic [3:0]    ram_be;
    logic [31:0]   ram_wdata;

    assign ram_idx   = (state_q == INIT) ? clr_idx_q : word_idx;
    assign ram_be    = clr_we ? 4'b1111 : (do_store ? req_st_be : 4'b0000);
    assign ram_wdata = clr_we ? '0 : req_st_wdata;

    // rdata_q only moves on a load, so a held response keeps its data.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (ram_be[i]) begin
                    mem_q[ram_idx][8*i +: 8] <= ram_wdata[8*i +: 8];
                end
            end
            if (do_load) begin
                rdata_q <= mem_q[ram_idx];
            end
        end
    end

    // ---------------- first response stage ----------------
    // Holds the decoded access alongside the RAM read so the lane is
    // extracted after the read; control only updates on responding accepts.
    logic        s0_valid_q, s0_fault_q, s0_load_q, s0_sign_q;
    logic [1:0]  s0_size_q, s0_lane_q;
    logic [31:0] s0_ext, s0_data;

    logic [31:0] rsp_st_wdata;
    logic [3:0]  rsp_st_be;
    logic        rsp_misalign;

    always_ff @(posedge clk) begin
        if (rst) begin
            s0_valid_q <= 1'b0;
            s0_fault_q <= 1'b0;
            s0_load_q  <= 1'b0;
            s0_sign_q  <= 1'b0;
            s0_size_q  <= '0;
            s0_lane_q  <= '0;
        end else begin
            s0_valid_q <= active;
            if (active) begin
                s0_fault_q <= fault;
                s0_load_q  <= ~req_store & ~fault;
                s0_sign_q  <= req_sign;
                s0_size_q  <= req_size;
                s0_lane_q  <= off[1:0];
            end
        end
    end

    data_mem_align u_rsp_align (
        .size_i     (s0_size_q),
        .sign_i     (s0_sign_q),
        .lane_i     (s0_lane_q),
        .st_data_i  ('0),
        .ld_word_i  (rdata_q),
        .st_wdata_o (rsp_st_wdata),
        .st_be_o    (rsp_st_be),
        .ld_data_o  (s0_ext),
        .misalign_o (rsp_misalign)
    );

    assign s0_data = s0_load_q ? s0_ext : '0;

    logic unused_align;
    assign unused_align = ^{rsp_st_wdata, rsp_st_be, rsp_misalign, req_ld_data};

    // ---------------- remaining latency ----------------
    logic        v_out, f_out;
    logic [31:0] d_out;

    if (READ_LAT == 1) begin : g_lat1
        assign v_out = s0_valid_q;
        assign d_out = s0_data;
        assign f_out = s0_fault_q;
    end else begin : g_latn
        // Valid shifts every cycle; data/fault only load behind a valid so
        // the last stage keeps the previous response between pulses.
        for (genvar k = 0; k < READ_LAT - 1; k++) begin : g_stage
            logic        v_in, f_in, v_q, f_q;
            logic [31:0] d_in, d_q;
            if (k == 0) begin : g_head
                assign v_in = s0_valid_q;
                assign d_in = s0_data;
                assign f_in = s0_fault_q;
            end else begin : g_body
                assign v_in = g_stage[k-1].v_q;
                assign d_in = g_stage[k-1].d_q;
                assign f_in = g_stage[k-1].f_q;
            end
            always_ff @(posedge clk) begin
                if (rst) begin
                    v_q <= 1'b0;
                    d_q <= '0;
                    f_q <= 1'b0;
                end else begin
                    v_q <= v_in;
                    if (v_in) begin
                        d_q <= d_in;
                        f_q <= f_in;
                    end
                end
            end
        end
        assign v_out = g_stage[READ_LAT-2].v_q;
        assign d_out = g_stage[READ_LAT-2].d_q;
        assign f_out = g_stage[READ_LAT-2].f_q;
    end

    assign rsp_valid = ~rst & v_out;
    assign data_out  = rst ? '0 : d_out;
    assign rsp_fault = ~rst & f_out;

endmodule
